// File: rtl/pwm_capture.sv
// pwm_capture: decodes an asynchronous PWM input into period, high time and an R-bit duty code.
// Latency: SYNC_STAGES cycles to edge detect (+FILT_LEN with PWM_CAP_GLITCH_FILT_EN), then R+1 cycles to meas_valid.
// Optional: define PWM_CAP_GLITCH_FILT_EN to reject input pulses shorter than FILT_LEN cycles.

module pwm_capture #(
  parameter int R           = 8,
  parameter int CW          = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pwm_in,
  input  logic          clr,
  output logic [CW-1:0] period,
  output logic [CW-1:0] high_time,
  output logic [R-1:0]  duty,
  output logic          meas_valid,
  output logic          stuck,
  output logic          stuck_level,
  output logic          overrun
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam int            DCW     = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {
    M_IDLE,
    M_HIGH,
    M_LOW
  } mstate_t;

  // Elaboration guard: the synchronizer needs two flops, the divider shift needs R >= 2.
  if (SYNC_STAGES < 2 || FILT_LEN < 1 || R < 2) begin : g_param_check
    $error("pwm_capture: need SYNC_STAGES >= 2, FILT_LEN >= 1, R >= 2");
  end

  // ---------------------------------------------------------------------------
  // Input path
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   cur;
  logic                   prev;
  logic                   rise;
  logic                   fall;

  // Synchronizer chain; resets high so it agrees with the previous-sample register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAP_GLITCH_FILT_EN
  localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic           filt_lvl;
  logic [FCW-1:0] filt_cnt;

  // Glitch filter: a new level is accepted after FILT_LEN consecutive samples at that level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_lvl <= 1'b1;
      filt_cnt <= '0;
    end else if (sync_out == filt_lvl) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FCW'(FILT_LEN - 1)) begin
      filt_lvl <= sync_out;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FCW'(1);
    end
  end

  assign cur = filt_lvl;
`else
  // No filter: the synchronizer output feeds edge detection directly.
  assign cur = sync_out;
`endif

  // Previous sample resets high so an input held high gives no rise at reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= 1'b1;
    end else begin
      prev <= cur;
    end
  end

  assign rise = ~prev & cur;
  assign fall = prev & ~cur;

  // ---------------------------------------------------------------------------
  // Measurement FSM
  // ---------------------------------------------------------------------------
  mstate_t       state, state_nxt;
  logic [CW-1:0] cnt_p, cnt_p_nxt;
  logic [CW-1:0] cnt_h, cnt_h_nxt;
  logic [CW-1:0] h_lat, h_lat_nxt;
  logic          complete;
  logic          timeout;

  // State and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= M_IDLE;
      cnt_p <= '0;
      cnt_h <= '0;
      h_lat <= '0;
    end else begin
      state <= state_nxt;
      cnt_p <= cnt_p_nxt;
      cnt_h <= cnt_h_nxt;
      h_lat <= h_lat_nxt;
    end
  end

  // Next-state: arm on the first rise, time the high and low phases, complete on the next rise.
  always_comb begin
    state_nxt = state;
    cnt_p_nxt = cnt_p;
    cnt_h_nxt = cnt_h;
    h_lat_nxt = h_lat;
    complete  = 1'b0;
    timeout   = 1'b0;
    if (clr) begin
      state_nxt = M_IDLE;
      cnt_p_nxt = '0;
      cnt_h_nxt = '0;
    end else begin
      case (state)
        M_IDLE: begin
          if (rise) begin
            state_nxt = M_HIGH;
            cnt_p_nxt = CW'(1);
            cnt_h_nxt = CW'(1);
          end
        end
        M_HIGH: begin
          if (cnt_p == CNT_MAX) begin
            timeout   = 1'b1;
            state_nxt = M_IDLE;
          end else begin
            cnt_p_nxt = cnt_p + CW'(1);
            cnt_h_nxt = cnt_h + CW'(1);
            if (fall) begin
              state_nxt = M_LOW;
              h_lat_nxt = cnt_h;
            end
          end
        end
        M_LOW: begin
          if (cnt_p == CNT_MAX) begin
            timeout   = 1'b1;
            state_nxt = M_IDLE;
          end else if (rise) begin
            complete  = 1'b1;
            state_nxt = M_HIGH;
            cnt_p_nxt = CW'(1);
            cnt_h_nxt = CW'(1);
          end else begin
            cnt_p_nxt = cnt_p + CW'(1);
          end
        end
        default: begin
          state_nxt = M_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Restoring divider: duty = floor(h * 2^R / p), one quotient bit per cycle
  // ---------------------------------------------------------------------------
  logic           div_busy;
  logic [DCW-1:0] div_cnt;
  logic [CW-1:0]  div_p;
  logic [CW-1:0]  div_h;
  logic [CW:0]    div_rem;
  logic [R-1:0]   div_q;
  logic [CW:0]    rem_sh;
  logic           rem_ge;
  logic [CW:0]    rem_step;
  logic [R-1:0]   q_step;
  logic           div_last;
  logic           accept;

  // h < p, so the first CW dividend bits leave remainder h; only the R appended zeros need steps.
  assign rem_sh   = div_rem << 1;
  assign rem_ge   = (rem_sh >= {1'b0, div_p});
  assign rem_step = rem_ge ? (rem_sh - {1'b0, div_p}) : rem_sh;
  assign q_step   = {div_q[R-2:0], rem_ge};
  assign div_last = div_busy && (div_cnt == DCW'(R - 1));
  // The divider counts as free during its final step, so a back-to-back completion is kept.
  assign accept   = complete && (!div_busy || div_last);

  // Divider datapath: load on an accepted completion, otherwise step while busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_busy <= 1'b0;
      div_cnt  <= '0;
      div_p    <= '0;
      div_h    <= '0;
      div_rem  <= '0;
      div_q    <= '0;
    end else if (clr) begin
      div_busy <= 1'b0;
      div_cnt  <= '0;
    end else begin
      if (div_busy) begin
        div_rem <= rem_step;
        div_q   <= q_step;
        div_cnt <= div_cnt + DCW'(1);
        if (div_last) begin
          div_busy <= 1'b0;
        end
      end
      if (accept) begin
        div_busy <= 1'b1;
        div_cnt  <= '0;
        div_p    <= cnt_p;
        div_h    <= h_lat;
        div_rem  <= {1'b0, h_lat};
        div_q    <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs and status flags
  // ---------------------------------------------------------------------------

  // Measurement outputs load together with the final quotient bit and pulse meas_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period     <= '0;
      high_time  <= '0;
      duty       <= '0;
      meas_valid <= 1'b0;
    end else if (clr) begin
      period     <= '0;
      high_time  <= '0;
      duty       <= '0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= div_last;
      if (div_last) begin
        period    <= div_p;
        high_time <= div_h;
        duty      <= q_step;
      end
    end
  end

  // Sticky overrun on a dropped completion; stuck set on timeout, cleared by a fresh measurement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun     <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else if (clr) begin
      overrun     <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      if (complete && !accept) begin
        overrun <= 1'b1;
      end
      if (div_last) begin
        stuck <= 1'b0;
      end
      if (timeout) begin
        stuck       <= 1'b1;
        stuck_level <= cur;
      end
    end
  end

endmodule
